// File: rtl/seq_pkg.sv
// Shared definitions for the melody sequencer and the front-panel logic:
// FSM state encoding, note-entry field layout and legal frequency range.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_NOTE  = 3'd3,
        S_GAP   = 3'd4,
        S_NEXT  = 3'd5
    } seq_state_t;

    // Note entry layout: [30:15] freq_hz, [14:12] wave, [11:0] dur_ticks
    localparam int unsigned FREQ_W   = 16;
    localparam int unsigned WAVE_W   = 3;
    localparam int unsigned DUR_W    = 12;
    localparam int unsigned ENTRY_W  = FREQ_W + WAVE_W + DUR_W;
    localparam int unsigned DUR_LSB  = 0;
    localparam int unsigned WAVE_LSB = DUR_LSB + DUR_W;
    localparam int unsigned FREQ_LSB = WAVE_LSB + WAVE_W;

    // Legal frequency range in Hz, shared with the panel register logic
    localparam logic [FREQ_W-1:0] FREQ_MIN_HZ = 16'd20;
    localparam logic [FREQ_W-1:0] FREQ_MAX_HZ = 16'd9999;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [FREQ_W-1:0] freq,
        input logic [WAVE_W-1:0] wave,
        input logic [DUR_W-1:0]  dur
    );
        return {freq, wave, dur};
    endfunction

    // Zero is a rest and passes through untouched
    function automatic logic [FREQ_W-1:0] clamp_freq(
        input logic [FREQ_W-1:0] freq,
        input logic [FREQ_W-1:0] lo,
        input logic [FREQ_W-1:0] hi
    );
        if (freq == '0)
            return '0;
        else if (freq < lo)
            return lo;
        else if (freq > hi)
            return hi;
        else
            return freq;
    endfunction

endpackage

// File: rtl/seq_tick_timer.sv
// Duration timer: a prescaler dividing mclk into ticks plus a tick
// down-counter. load restarts both; expire is high for the final cycle
// of the loaded duration (count * TICK_DIV cycles after load).
module seq_tick_timer
    import seq_pkg::*;
#(
    parameter int unsigned TICK_DIV = 16000
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic             load,
    input  logic [DUR_W-1:0] count,
    output logic             expire
);

    localparam int unsigned PW = ($clog2(TICK_DIV) < 1) ? 1 : $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]    pre;
    logic [DUR_W-1:0] ticks;
    logic             active;

    assign expire = active && (pre == PRE_LAST) && (ticks <= DUR_W'(1));

    // Prescaler and tick counter; idle once the loaded duration has elapsed
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            pre    <= '0;
            ticks  <= '0;
            active <= 1'b0;
        end else if (load) begin
            pre    <= '0;
            ticks  <= count;
            active <= 1'b1;
        end else if (active) begin
            if (pre == PRE_LAST) begin
                pre <= '0;
                if (ticks <= DUR_W'(1))
                    active <= 1'b0;
                else
                    ticks <= ticks - DUR_W'(1);
            end else begin
                pre <= pre + PW'(1);
            end
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Autonomous note sequencer: steps through a programmable note table,
// hands each frequency to the period path via valid/ready, and drives the
// wavetable select and PWM gate for the note and the silent gap after it.
module melody_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned       DEPTH     = 16,
    parameter int unsigned       AW        = 4,
    parameter int unsigned       TICK_DIV  = 16000,
    parameter int unsigned       GAP_TICKS = 20,
    parameter logic [FREQ_W-1:0] FREQ_MIN  = 16'd20,
    parameter logic [FREQ_W-1:0] FREQ_MAX  = 16'd9999
) (
    input  logic                mclk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [ENTRY_W-1:0]  wr_data,
    input  logic [AW:0]         seq_len,
    input  logic                loop,
    input  logic                start,
    input  logic                stop,
    output logic [FREQ_W-1:0]   freq_out,
    output logic                freq_valid,
    input  logic                freq_ready,
    output logic [WAVE_W-1:0]   wave_sel,
    output logic                gate,
    output logic [AW-1:0]       step_idx,
    output logic                playing,
    output logic                done
);

    localparam logic [DUR_W-1:0] GAP_CNT = DUR_W'(GAP_TICKS);
    localparam bit               HAS_GAP = (GAP_TICKS != 0);

    seq_state_t         state;
    logic [ENTRY_W-1:0] note_mem [DEPTH];
    logic [ENTRY_W-1:0] cur_entry;
    logic [FREQ_W-1:0]  cur_freq;
    logic [WAVE_W-1:0]  cur_wave;
    logic [DUR_W-1:0]   cur_dur;
    logic [DUR_W-1:0]   dur_q;
    logic [AW:0]        next_idx;
    logic               restart;
    logic               tmr_load;
    logic [DUR_W-1:0]   tmr_count;
    logic               tmr_expire;

    assign cur_entry = note_mem[step_idx];
    assign cur_freq  = cur_entry[FREQ_LSB +: FREQ_W];
    assign cur_wave  = cur_entry[WAVE_LSB +: WAVE_W];
    assign cur_dur   = cur_entry[DUR_LSB  +: DUR_W];
    assign next_idx  = {1'b0, step_idx} + (AW+1)'(1);
    assign restart   = start && (seq_len != '0);
    assign playing   = (state != S_IDLE);

    // Note table write port; contents survive reset
    always_ff @(posedge mclk) begin
        if (wr_en)
            note_mem[wr_addr] <= wr_data;
    end

    // Timer reload on entry to NOTE (from LOAD for rests, from ISSUE on handshake) and to GAP
    always_comb begin
        tmr_load  = 1'b0;
        tmr_count = cur_dur;
        case (state)
            S_LOAD: begin
                tmr_load  = (cur_dur != '0) && (cur_freq == '0);
                tmr_count = cur_dur;
            end
            S_ISSUE: begin
                tmr_load  = freq_ready;
                tmr_count = dur_q;
            end
            S_NOTE: begin
                tmr_load  = tmr_expire && HAS_GAP;
                tmr_count = GAP_CNT;
            end
            default: ;
        endcase
    end

    seq_tick_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .mclk   (mclk),
        .rst    (rst),
        .load   (tmr_load),
        .count  (tmr_count),
        .expire (tmr_expire)
    );

    // Sequencer FSM with registered outputs; stop overrides start, start restarts from entry 0
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            step_idx   <= '0;
            freq_out   <= '0;
            wave_sel   <= '0;
            gate       <= 1'b0;
            freq_valid <= 1'b0;
            done       <= 1'b0;
            dur_q      <= '0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state      <= S_IDLE;
                gate       <= 1'b0;
                freq_valid <= 1'b0;
            end else if (restart) begin
                state      <= S_LOAD;
                step_idx   <= '0;
                gate       <= 1'b0;
                freq_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: ;
                    S_LOAD: begin
                        wave_sel <= cur_wave;
                        freq_out <= clamp_freq(cur_freq, FREQ_MIN, FREQ_MAX);
                        dur_q    <= cur_dur;
                        if (cur_dur == '0) begin
                            state <= S_NEXT;
                        end else if (cur_freq == '0) begin
                            state <= S_NOTE;
                        end else begin
                            state      <= S_ISSUE;
                            freq_valid <= 1'b1;
                        end
                    end
                    S_ISSUE: begin
                        if (freq_ready) begin
                            freq_valid <= 1'b0;
                            gate       <= 1'b1;
                            state      <= S_NOTE;
                        end
                    end
                    S_NOTE: begin
                        if (tmr_expire) begin
                            gate  <= 1'b0;
                            state <= HAS_GAP ? S_GAP : S_NEXT;
                        end
                    end
                    S_GAP: begin
                        if (tmr_expire)
                            state <= S_NEXT;
                    end
                    S_NEXT: begin
                        if (next_idx < seq_len) begin
                            step_idx <= next_idx[AW-1:0];
                            state    <= S_LOAD;
                        end else if (loop) begin
                            step_idx <= '0;
                            state    <= S_LOAD;
                        end else begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Autonomous note sequencer for the synthesizer voice: plays a programmable table of notes, each with a frequency, waveform and duration, without front-panel interaction.
- Per note it hands a frequency word to the period-calculation path (divider → variable clock divider → wavetable) through a valid/ready handshake.
- It drives the wavetable select and the PWM output gate.
- Sits beside the front-panel register logic; the top level muxes between panel values and sequencer values.

Parameters:
- DEPTH, 16, number of note-table entries (power of two)
- AW, 4, table address width, log2(DEPTH)
- TICK_DIV, 16000, mclk cycles per duration tick (1 ms at 16 MHz)
- GAP_TICKS, 20, silent ticks inserted after every note; 0 disables the gap
- FREQ_MIN, 20, lowest legal frequency in Hz
- FREQ_MAX, 9999, highest legal frequency in Hz

Ports:
- mclk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- wr_en  in  1  write one table entry this cycle
- wr_addr  in  AW  table entry address
- wr_data  in  31  entry fields: [30:15] freq_hz, [14:12] wave, [11:0] dur_ticks
- seq_len  in  AW+1  number of entries to play, 0..DEPTH
- loop  in  1  at the end of the table, wrap to entry 0 instead of stopping
- start  in  1  single-cycle pulse: begin playback from entry 0
- stop  in  1  single-cycle pulse: abort playback
- freq_out  out  16  frequency word for the period path
- freq_valid  out  1  freq_out is valid, held until accepted
- freq_ready  in  1  period path accepts freq_out
- wave_sel  out  3  wavetable select for the current note
- gate  out  1  PWM output enable
- step_idx  out  AW  index of the current entry
- playing  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a non-looping sequence completes

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; step_idx=0, freq_out=0, wave_sel=0, gate=0, freq_valid=0, playing=0, done=0.
  - Table contents are not reset.
  - Reset mid-note drops gate and freq_valid immediately.
- Table:
  - DEPTH×31 register array, written synchronously on wr_en.
  - Writes are allowed while playing and take effect only for entries not yet loaded.
- States: IDLE, LOAD, ISSUE, NOTE, GAP, NEXT.
- IDLE → LOAD:
  - Transition on start, but only when seq_len≠0; otherwise start is ignored.
  - step_idx←0.
- LOAD (1 cycle):
  - Latch the entry at step_idx and set wave_sel.
  - Clamp freq to [FREQ_MIN, FREQ_MAX]; freq=0 is a rest and is not clamped.
  - dur=0 → NEXT.
  - Rest → NOTE, skipping ISSUE; gate stays 0.
  - Otherwise → ISSUE.
- ISSUE:
  - freq_valid=1 and freq_out is held stable until freq_valid&freq_ready.
  - On the handshake: freq_valid←0, → NOTE.
  - There is no timeout.
- NOTE:
  - gate=1, or 0 for a rest.
  - Prescaler and tick counter clear on entry.
  - Lasts exactly dur·TICK_DIV cycles, then → GAP, or → NEXT when GAP_TICKS=0.
- GAP: gate=0 for exactly GAP_TICKS·TICK_DIV cycles, then → NEXT.
- NEXT (1 cycle):
  - If step_idx+1 < seq_len: step_idx++, → LOAD.
  - Otherwise, if loop: step_idx←0, → LOAD.
  - Otherwise: done=1, → IDLE, step_idx unchanged.
  - seq_len is sampled in NEXT, so shrinking it mid-play ends the sequence at the next NEXT.
- Stop:
  - stop in any state → IDLE next cycle; gate=0, freq_valid=0, no done.
  - start and stop in the same cycle: stop wins.
  - start while playing restarts at LOAD with step_idx=0; an ISSUE handshake in progress is abandoned.
- Widths:
  - Prescaler is ceil(log2(TICK_DIV)) bits; tick counter is 12 bits.
  - Comparisons are unsigned; no wrap occurs within a note.

Decomposition:
- Shared package seq_pkg:
  - state encoding (3-bit enum);
  - entry field offsets/widths (FREQ 16, WAVE 3, DUR 12);
  - entry packing function;
  - FREQ_MIN/FREQ_MAX constants, also used by the panel logic.
- One sub-module, seq_tick_timer:
  - prescaler plus tick down-counter;
  - inputs: load, count value;
  - output: expire pulse;
  - used by both NOTE and GAP.

Test Plan (TICK_DIV=4, GAP_TICKS=1, freq_ready tied 1 unless noted):
- Write {440, wave 2, dur 3}, seq_len=1, start → freq_out=440 valid 1 cycle; wave_sel=2; gate high 12 cycles; gate low 4 cycles; done pulse; playing=0.
- Entries {10,1,2} and {12000,0,2} → freq_out 20 then 9999 (clamped).
- Rest entry {0,3,2} → no freq_valid; gate stays 0 for 8 cycles.
- Entry with dur=0 → entry skipped.
- freq_ready held 0 for 7 cycles → freq_valid and freq_out stable throughout; NOTE begins the cycle after ready rises.
- seq_len=2, loop=1 → step_idx sequence 0,1,0,1, no done; stop mid-NOTE → gate=0 and IDLE next cycle, no done.
- rst asserted mid-NOTE → all outputs 0 asynchronously; start+stop in the same cycle → stays IDLE.
- start with seq_len=0 → ignored.
